// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requester handshakes and register-file write port bundle
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
);
  logic              hold;
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic              last_grant;
  logic [CNT_W-1:0]  conflict_count;
  modport slave (
    input  hold, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, rf_we, rf_addr, rf_wdata, last_grant, conflict_count
  );
  modport master (
    output hold, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, rf_we, rf_addr, rf_wdata, last_grant, conflict_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between ALU and load writeback
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int CNT_W      = 8,
  parameter int FIXED_PRIO = 0
) (
  input logic clk,
  input logic reset,
  regfile_wb_arbiter_if.slave bus
);
  logic              w_g0;
  logic              w_g1;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic [CNT_W-1:0]  r_cnt;
  // req0 wins when alone, under fixed priority, or when req1 was granted last
  assign w_g0 = !reset && !bus.hold && bus.req0_valid &&
                (!bus.req1_valid || (FIXED_PRIO != 0) || r_last);
  assign w_g1 = !reset && !bus.hold && bus.req1_valid && !w_g0;
  assign w_addr = w_g1 ? bus.req1_addr : bus.req0_addr;
  assign w_data = w_g1 ? bus.req1_data : bus.req0_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_last <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_we <= (w_g0 || w_g1) && (w_addr != '0);
      if (w_g0 || w_g1) begin
        r_addr <= w_addr;
        r_data <= w_data;
        r_last <= w_g1;
      end
      if (bus.req0_valid && bus.req1_valid && !bus.hold && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end
  assign bus.req0_ready     = w_g0;
  assign bus.req1_ready     = w_g1;
  assign bus.rf_we          = r_we;
  assign bus.rf_addr        = r_addr;
  assign bus.rf_wdata       = r_data;
  assign bus.last_grant     = r_last;
  assign bus.conflict_count = r_cnt;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector table plus reset corner sequences
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [4:0]  a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic h, v0; logic [4:0] a0; logic [31:0] d0;
    logic v1; logic [4:0] a1; logic [31:0] d1;
    logic r0, r1, we; logic [4:0] addr; logic [31:0] data; logic last; logic [7:0] cnt;
  } vec_t;
  vec_t tbl[13];
  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(8)) b0 ();
  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) b1 ();
  assign b0.hold = hold;
  assign b0.req0_valid = v0;
  assign b0.req0_addr = a0;
  assign b0.req0_data = d0;
  assign b0.req1_valid = v1;
  assign b0.req1_addr = a1;
  assign b0.req1_data = d1;
  assign b1.hold = hold;
  assign b1.req0_valid = v0;
  assign b1.req0_addr = a0;
  assign b1.req0_data = d0;
  assign b1.req1_valid = v1;
  assign b1.req1_addr = a1;
  assign b1.req1_data = d1;
  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(8), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset), .bus(b0.slave));
  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(2), .FIXED_PRIO(1)) dut_fx (
    .clk(clk), .reset(reset), .bus(b1.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask
  initial begin
    tbl[0]  = '{0,1,3,32'd20,0,0,0,                         1,0,1,3,32'd20,0,1};
    tbl[0].cnt = 0;
    tbl[1]  = '{0,0,0,0,1,0,32'hFFFF_FFFF,                 0,1,0,0,32'hFFFF_FFFF,1,0};
    tbl[2]  = '{0,0,0,0,0,0,0,                             0,0,0,0,32'hFFFF_FFFF,1,0};
    tbl[3]  = '{0,1,4,32'hA000_0001,1,5,32'hB000_0001,     1,0,1,4,32'hA000_0001,0,1};
    tbl[4]  = '{0,1,6,32'hA000_0002,1,5,32'hB000_0001,     0,1,1,5,32'hB000_0001,1,2};
    tbl[5]  = '{0,1,6,32'hA000_0002,1,7,32'hB000_0002,     1,0,1,6,32'hA000_0002,0,3};
    tbl[6]  = '{0,1,8,32'hA000_0003,1,7,32'hB000_0002,     0,1,1,7,32'hB000_0002,1,4};
    tbl[7]  = '{1,1,8,32'hA000_0003,1,9,32'hB000_0003,     0,0,0,7,32'hB000_0002,1,4};
    tbl[8]  = '{1,1,8,32'hA000_0003,1,9,32'hB000_0003,     0,0,0,7,32'hB000_0002,1,4};
    tbl[9]  = '{1,1,8,32'hA000_0003,1,9,32'hB000_0003,     0,0,0,7,32'hB000_0002,1,4};
    tbl[10] = '{0,1,8,32'hA000_0003,1,9,32'hB000_0003,     1,0,1,8,32'hA000_0003,0,5};
    tbl[11] = '{0,0,0,0,1,8,32'hB000_0004,                 0,1,1,8,32'hB000_0004,1,5};
    tbl[12] = '{0,0,0,0,0,0,0,                             0,0,0,8,32'hB000_0004,1,5};
    tbl[0].cnt = 0;
    v0 = 1; a0 = 3; d0 = 20;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready0", {31'd0, b0.req0_ready}, 0);
    chk("rst_we", {31'd0, b0.rf_we}, 0);
    chk("rst_addr", {27'd0, b0.rf_addr}, 0);
    chk("rst_cnt", {24'd0, b0.conflict_count}, 0);
    chk("rst_last", {31'd0, b0.last_grant}, 1);
    reset = 0;
    for (int i = 0; i < 13; i++) begin
      hold = tbl[i].h; v0 = tbl[i].v0; a0 = tbl[i].a0; d0 = tbl[i].d0;
      v1 = tbl[i].v1; a1 = tbl[i].a1; d1 = tbl[i].d1;
      #1;
      chk($sformatf("v%0d_ready0", i), {31'd0, b0.req0_ready}, {31'd0, tbl[i].r0});
      chk($sformatf("v%0d_ready1", i), {31'd0, b0.req1_ready}, {31'd0, tbl[i].r1});
      chk($sformatf("v%0d_fx_ready0", i), {31'd0, b1.req0_ready}, {31'd0, v0 & ~hold});
      chk($sformatf("v%0d_fx_ready1", i), {31'd0, b1.req1_ready}, {31'd0, v1 & ~v0 & ~hold});
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_we", i), {31'd0, b0.rf_we}, {31'd0, tbl[i].we});
      chk($sformatf("v%0d_addr", i), {27'd0, b0.rf_addr}, {27'd0, tbl[i].addr});
      chk($sformatf("v%0d_wdata", i), b0.rf_wdata, tbl[i].data);
      chk($sformatf("v%0d_last", i), {31'd0, b0.last_grant}, {31'd0, tbl[i].last});
      chk($sformatf("v%0d_cnt", i), {24'd0, b0.conflict_count}, {24'd0, tbl[i].cnt});
      chk($sformatf("v%0d_fx_cnt", i), {30'd0, b1.conflict_count},
          (tbl[i].cnt > 3) ? 32'd3 : {24'd0, tbl[i].cnt});
    end
    v0 = 1; a0 = 10; d0 = 32'hC0DE_0001; v1 = 1; a1 = 11; d1 = 32'hC0DE_0002;
    repeat (2) @(negedge clk);
    chk("mid_we_before_rst", {31'd0, b0.rf_we}, 1);
    chk("mid_fx_cnt_sat", {30'd0, b1.conflict_count}, 3);
    #2 reset = 1;
    #1;
    chk("async_rst_we", {31'd0, b0.rf_we}, 0);
    chk("async_rst_cnt", {24'd0, b0.conflict_count}, 0);
    chk("async_rst_fx_cnt", {30'd0, b1.conflict_count}, 0);
    chk("async_rst_ready0", {31'd0, b0.req0_ready}, 0);
    chk("async_rst_ready1", {31'd0, b0.req1_ready}, 0);
    chk("async_rst_last", {31'd0, b0.last_grant}, 1);
    @(negedge clk);
    reset = 0;
    #1;
    chk("post_rst_ready0", {31'd0, b0.req0_ready}, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
